uart_fifo_core: RTL and testbench

- Parametrised full-duplex UART for the peripheral bus, running in a single clock domain.
- Successor to the fixed 8N1 UART. It adds:
  - compile-time baud divider;
  - configurable data width and stop bits;
  - TX and RX FIFOs of parameter depth;
  - 16x oversampled receive with a start-bit glitch filter;
  - sticky overrun and framing error flags.
- The CPU pushes bytes with a write strobe and pops received bytes with a read strobe.

---
 rtl/uart_fifo_core.sv | 354 +++++++++++++++++++++++++++++++++++
 tb/tb_uart_fifo_core.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_core.sv
// Full-duplex UART with TX/RX FIFOs, 16x oversampled receive and sticky error flags.
// Define UART_PARITY_EN to add a parity bit (PARITY_ODD selects odd parity) and rx_parity_err.
module uart_fifo_core #(
    parameter int unsigned CLK_HZ        = 50000000,
    parameter int unsigned BAUD          = 115200,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned STOP_BITS     = 1,
    parameter int unsigned TX_DEPTH_LOG2 = 2,
`ifdef UART_PARITY_EN
    parameter bit          PARITY_ODD    = 1'b0,
`endif
    parameter int unsigned RX_DEPTH_LOG2 = 2
) (
    input  logic                 sclk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_wr,
    output logic                 tx_full,
    output logic                 tx_busy,
    output logic                 dout,
    input  logic                 din,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_rd,
    output logic                 rx_overrun,
    output logic                 rx_frame_err,
`ifdef UART_PARITY_EN
    output logic                 rx_parity_err,
`endif
    input  logic                 err_clr
);

    localparam int unsigned DivRaw  = CLK_HZ / (BAUD * 16);
    localparam int unsigned Div     = (DivRaw < 1) ? 1 : DivRaw;
    localparam int unsigned DivW    = (Div > 1) ? $clog2(Div) : 1;
    localparam int unsigned TxDepth = 1 << TX_DEPTH_LOG2;
    localparam int unsigned RxDepth = 1 << RX_DEPTH_LOG2;

    localparam logic [DivW-1:0]          DivLast  = DivW'(Div - 1);
    localparam logic [3:0]               BitLast  = 4'(DATA_BITS - 1);
    localparam logic [3:0]               StopLast = 4'(STOP_BITS - 1);
    localparam logic [TX_DEPTH_LOG2:0]   TxPtrOne = 1;
    localparam logic [RX_DEPTH_LOG2:0]   RxPtrOne = 1;

    // ---------------- tick generator ----------------
    logic [DivW-1:0] div_q;
    logic            tick;

    assign tick = (div_q == DivLast);

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) div_q <= '0;
        else       div_q <= tick ? '0 : div_q + DivW'(1);
    end

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0]   tx_mem [TxDepth];
    logic [TX_DEPTH_LOG2:0] tx_wp_q, tx_rp_q;
    logic                   tx_empty, tx_push, tx_pop;
    logic [DATA_BITS-1:0]   tx_head;

    assign tx_empty = (tx_wp_q == tx_rp_q);
    assign tx_full  = (tx_wp_q[TX_DEPTH_LOG2] != tx_rp_q[TX_DEPTH_LOG2]) &&
                      (tx_wp_q[TX_DEPTH_LOG2-1:0] == tx_rp_q[TX_DEPTH_LOG2-1:0]);
    assign tx_push  = tx_wr && (!tx_full || tx_pop);
    assign tx_head  = tx_mem[tx_rp_q[TX_DEPTH_LOG2-1:0]];

    always_ff @(posedge sclk) begin
        if (tx_push) tx_mem[tx_wp_q[TX_DEPTH_LOG2-1:0]] <= tx_data;
    end

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            tx_wp_q <= '0;
            tx_rp_q <= '0;
        end else begin
            if (tx_push) tx_wp_q <= tx_wp_q + TxPtrOne;
            if (tx_pop)  tx_rp_q <= tx_rp_q + TxPtrOne;
        end
    end

    // ---------------- TX FSM ----------------
    typedef enum logic [2:0] {
        StTxIdle,
        StTxStart,
        StTxData,
`ifdef UART_PARITY_EN
        StTxParity,
`endif
        StTxStop
    } tx_state_e;

    tx_state_e            tx_state_q, tx_state_d;
    logic [3:0]           tx_cnt_q, tx_cnt_d, tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
    logic                 dout_q, dout_d, tx_end, tx_load;
`ifdef UART_PARITY_EN
    logic                 tx_par_q, tx_par_d;
`endif

    assign tx_end  = tick && (tx_cnt_q == 4'd15);
    assign dout    = dout_q;
    assign tx_busy = (tx_state_q != StTxIdle) || !tx_empty;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        dout_d     = dout_q;
        tx_pop     = 1'b0;
        tx_load    = 1'b0;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        if (tick && (tx_state_q != StTxIdle)) tx_cnt_d = tx_cnt_q + 4'd1;
        unique case (tx_state_q)
            StTxIdle: tx_load = tick && !tx_empty;
            StTxStart: begin
                if (tx_end) begin
                    tx_state_d = StTxData;
                    tx_bit_d   = '0;
                    dout_d     = tx_sh_q[0];
                    tx_sh_d    = tx_sh_q >> 1;
                end
            end
            StTxData: begin
                if (tx_end) begin
                    if (tx_bit_q == BitLast) begin
                        tx_bit_d = '0;
`ifdef UART_PARITY_EN
                        tx_state_d = StTxParity;
                        dout_d     = tx_par_q;
`else
                        tx_state_d = StTxStop;
                        dout_d     = 1'b1;
`endif
                    end else begin
                        tx_bit_d = tx_bit_q + 4'd1;
                        dout_d   = tx_sh_q[0];
                        tx_sh_d  = tx_sh_q >> 1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            StTxParity: begin
                if (tx_end) begin
                    tx_state_d = StTxStop;
                    tx_bit_d   = '0;
                    dout_d     = 1'b1;
                end
            end
`endif
            StTxStop: begin
                if (tx_end) begin
                    if (tx_bit_q == StopLast) begin
                        // Reload straight from the stop bit so back-to-back frames have no gap.
                        if (!tx_empty) tx_load = 1'b1;
                        else           tx_state_d = StTxIdle;
                    end else begin
                        tx_bit_d = tx_bit_q + 4'd1;
                    end
                end
            end
            default: tx_state_d = StTxIdle;
        endcase
        if (tx_load) begin
            tx_pop     = 1'b1;
            tx_sh_d    = tx_head;
            tx_cnt_d   = '0;
            dout_d     = 1'b0;
            tx_state_d = StTxStart;
`ifdef UART_PARITY_EN
            tx_par_d   = (^tx_head) ^ PARITY_ODD;
`endif
        end
    end

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            tx_state_q <= StTxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            dout_q     <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            dout_q     <= dout_d;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    // ---------------- RX FIFO ----------------
    logic [DATA_BITS-1:0]   rx_mem [RxDepth];
    logic [RX_DEPTH_LOG2:0] rx_wp_q, rx_rp_q;
    logic                   rx_full, rx_push_req, rx_push, rx_pop, rx_ovr_set;
    logic [DATA_BITS-1:0]   rx_sh_q, rx_sh_d;

    assign rx_valid   = (rx_wp_q != rx_rp_q);
    assign rx_full    = (rx_wp_q[RX_DEPTH_LOG2] != rx_rp_q[RX_DEPTH_LOG2]) &&
                        (rx_wp_q[RX_DEPTH_LOG2-1:0] == rx_rp_q[RX_DEPTH_LOG2-1:0]);
    assign rx_pop     = rx_rd && rx_valid;
    assign rx_push    = rx_push_req && (!rx_full || rx_pop);
    assign rx_ovr_set = rx_push_req && !rx_push;
    assign rx_data    = rx_mem[rx_rp_q[RX_DEPTH_LOG2-1:0]];

    always_ff @(posedge sclk) begin
        if (rx_push) rx_mem[rx_wp_q[RX_DEPTH_LOG2-1:0]] <= rx_sh_q;
    end

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            rx_wp_q <= '0;
            rx_rp_q <= '0;
        end else begin
            if (rx_push) rx_wp_q <= rx_wp_q + RxPtrOne;
            if (rx_pop)  rx_rp_q <= rx_rp_q + RxPtrOne;
        end
    end

    // ---------------- RX FSM ----------------
    typedef enum logic [2:0] {
        StRxIdle,
        StRxStart,
        StRxData,
`ifdef UART_PARITY_EN
        StRxParity,
`endif
        StRxStop,
        StRxWait
    } rx_state_e;

    rx_state_e  rx_state_q, rx_state_d;
    logic [1:0] rx_sync_q;
    logic       rx_sync, rx_prev_q, rx_mid, rx_end, rx_fe_set;
    logic [3:0] rx_cnt_q, rx_cnt_d, rx_bit_q, rx_bit_d;
`ifdef UART_PARITY_EN
    logic       rx_par_set, rx_par_q;
    assign rx_parity_err = rx_par_q;
`endif

    assign rx_sync = rx_sync_q[1];
    assign rx_mid  = tick && (rx_cnt_q == 4'd7);
    assign rx_end  = tick && (rx_cnt_q == 4'd15);

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_sh_d     = rx_sh_q;
        rx_push_req = 1'b0;
        rx_fe_set   = 1'b0;
`ifdef UART_PARITY_EN
        rx_par_set  = 1'b0;
`endif
        if (tick) rx_cnt_d = rx_cnt_q + 4'd1;
        unique case (rx_state_q)
            StRxIdle: begin
                if (rx_prev_q && !rx_sync) begin
                    rx_state_d = StRxStart;
                    rx_cnt_d   = '0;
                end
            end
            StRxStart: begin
                // Mid-start recheck rejects short low glitches.
                if (rx_mid) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync ? StRxIdle : StRxData;
                end
            end
            StRxData: begin
                if (rx_end) begin
                    rx_sh_d = {rx_sync, rx_sh_q[DATA_BITS-1:1]};
                    if (rx_bit_q == BitLast) begin
`ifdef UART_PARITY_EN
                        rx_state_d = StRxParity;
`else
                        rx_state_d = StRxStop;
`endif
                    end else begin
                        rx_bit_d = rx_bit_q + 4'd1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            StRxParity: begin
                if (rx_end) begin
                    rx_par_set = (rx_sync != ((^rx_sh_q) ^ PARITY_ODD));
                    rx_state_d = StRxStop;
                end
            end
`endif
            StRxStop: begin
                if (rx_end) begin
                    if (rx_sync) begin
                        rx_push_req = 1'b1;
                        rx_state_d  = StRxIdle;
                    end else begin
                        rx_fe_set  = 1'b1;
                        rx_state_d = StRxWait;
                    end
                end
            end
            StRxWait: if (rx_sync) rx_state_d = StRxIdle;
            default:  rx_state_d = StRxIdle;
        endcase
    end

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            rx_sync_q    <= 2'b11;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= StRxIdle;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_sh_q      <= '0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_q     <= 1'b0;
`endif
        end else begin
            rx_sync_q  <= {rx_sync_q[0], din};
            rx_prev_q  <= rx_sync;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            if (err_clr) begin
                rx_overrun   <= 1'b0;
                rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
                rx_par_q     <= 1'b0;
`endif
            end else begin
                if (rx_ovr_set) rx_overrun   <= 1'b1;
                if (rx_fe_set)  rx_frame_err <= 1'b1;
`ifdef UART_PARITY_EN
                if (rx_par_set) rx_par_q     <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_uart_fifo_core.sv
// Scoreboard bench for uart_fifo_core at default parameters (8N1, 432 clocks per bit, depth 4).
module tb_uart_fifo_core;

    localparam int BIT   = 432;
    localparam int DEPTH = 4;

    logic       sclk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_wr = 1'b0;
    logic       tx_full, tx_busy, dout, din;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_rd = 1'b0;
    logic       rx_overrun, rx_frame_err;
    logic       err_clr = 1'b0;

    logic       loop = 1'b0;
    logic       bench_din = 1'b1;
    assign din = loop ? dout : bench_din;

    uart_fifo_core dut (
        .sclk        (sclk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_wr       (tx_wr),
        .tx_full     (tx_full),
        .tx_busy     (tx_busy),
        .dout        (dout),
        .din         (din),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_rd       (rx_rd),
        .rx_overrun  (rx_overrun),
        .rx_frame_err(rx_frame_err),
        .err_clr     (err_clr)
    );

    always #5 sclk = ~sclk;

    int         total = 0;
    int         bad = 0;
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    bit         mon_en = 1'b0;
    bit         drain_en = 1'b1;
    bit         ovr_exp = 1'b0;
    bit         fe_exp = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference RX model: a good frame is queued unless the undrained FIFO already holds DEPTH.
    task automatic expect_rx(input logic [7:0] b);
        if (!drain_en && rx_exp.size() >= DEPTH) ovr_exp = 1'b1;
        else rx_exp.push_back(b);
    endtask

    task automatic push_tx(input logic [7:0] b);
        @(negedge sclk);
        tx_data = b;
        tx_wr   = 1'b1;
        @(negedge sclk);
        tx_wr   = 1'b0;
    endtask

    task automatic wait_dout_low(input string name);
        int n = 0;
        while (dout && n < 2000) begin
            @(negedge sclk);
            n++;
        end
        check({name, "_start_seen"}, int'(dout), 0);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((tx_exp.size() != 0 || rx_exp.size() != 0 || tx_busy || rx_valid) && n < budget) begin
            @(negedge sclk);
            n++;
        end
        check({name, "_idle"}, int'(n < budget), 1);
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop);
        bench_din = 1'b0;
        repeat (BIT) @(negedge sclk);
        for (int i = 0; i < 8; i++) begin
            bench_din = b[i];
            repeat (BIT) @(negedge sclk);
        end
        bench_din = stop;
        repeat (BIT) @(negedge sclk);
        bench_din = 1'b1;
    endtask

    // Line monitor: decodes frames on dout at mid-bit and compares against the TX queue.
    initial begin : tx_mon
        logic       prev;
        logic [7:0] b;
        logic [7:0] e;
        prev = 1'b1;
        forever begin
            @(negedge sclk);
            if (mon_en && !reset && prev && !dout) begin
                repeat (BIT / 2) @(negedge sclk);
                check("tx_start_bit", int'(dout), 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge sclk);
                    b[i] = dout;
                end
                repeat (BIT) @(negedge sclk);
                check("tx_stop_bit", int'(dout), 1);
                if (tx_exp.size() == 0) begin
                    check("tx_unexpected_frame", int'(b), -1);
                end else begin
                    e = tx_exp.pop_front();
                    check("tx_byte", int'(b), int'(e));
                end
            end
            prev = dout;
        end
    end

    // RX monitor: pops the FIFO whenever data is presented and compares against the RX queue.
    initial begin : rx_mon
        logic [7:0] e;
        forever begin
            @(negedge sclk);
            rx_rd = 1'b0;
            if (drain_en && !reset && rx_valid) begin
                if (rx_exp.size() == 0) begin
                    check("rx_unexpected_byte", int'(rx_data), -1);
                end else begin
                    e = rx_exp.pop_front();
                    check("rx_data", int'(rx_data), int'(e));
                end
                rx_rd = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #980000;
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        int occ;
        logic [7:0] b;

        // Reset values
        repeat (3) @(negedge sclk);
        check("rst_dout", int'(dout), 1);
        check("rst_tx_full", int'(tx_full), 0);
        check("rst_tx_busy", int'(tx_busy), 0);
        check("rst_rx_valid", int'(rx_valid), 0);
        check("rst_overrun", int'(rx_overrun), 0);
        check("rst_frame_err", int'(rx_frame_err), 0);
        reset = 1'b0;

        // Reset 300 clocks into 0xA5 abandons the frame immediately
        push_tx(8'hA5);
        wait_dout_low("abort");
        repeat (300) @(negedge sclk);
        reset = 1'b1;
        #1;
        check("abort_dout_high", int'(dout), 1);
        check("abort_busy_low", int'(tx_busy), 0);
        repeat (2) @(negedge sclk);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge sclk);
            if (!dout || tx_busy) n++;
        end
        check("abort_line_quiet", n, 0);

        // 0x55 framing and tx_busy fall at exactly 10 bit times
        mon_en = 1'b1;
        loop   = 1'b1;
        tx_exp.push_back(8'h55);
        expect_rx(8'h55);
        push_tx(8'h55);
        wait_dout_low("f55");
        n = 0;
        while (tx_busy && n < 6000) begin
            @(negedge sclk);
            n++;
        end
        check("f55_busy_fall_clocks", n, 10 * BIT);
        wait_idle("f55", 2000);

        // 0x3C loopback: rx_valid near end of frame, rx_rd clears it
        tx_exp.push_back(8'h3C);
        expect_rx(8'h3C);
        push_tx(8'h3C);
        wait_dout_low("f3c");
        n = 0;
        while (!rx_valid && n < 12 * BIT) begin
            @(negedge sclk);
            n++;
        end
        check("f3c_rx_valid_window", int'(n >= 9 * BIT && n <= 11 * BIT), 1);
        repeat (2) @(negedge sclk);
        check("f3c_rd_clears_valid", int'(rx_valid), 0);
        wait_idle("f3c", 2000);

        // FIFO fill right after reset: no tick (hence no pop) within the first pushes
        @(negedge sclk);
        reset = 1'b1;
        @(negedge sclk);
        reset = 1'b0;
        occ = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge sclk);
            if (i > 0) check("fill_tx_full", int'(tx_full), int'(occ == DEPTH));
            b       = 8'(i + 1);
            tx_data = b;
            tx_wr   = 1'b1;
            if (occ < DEPTH) begin
                occ++;
                tx_exp.push_back(b);
                expect_rx(b);
            end
        end
        @(negedge sclk);
        tx_wr = 1'b0;
        check("fill_tx_full_after5", int'(tx_full), 1);
        wait_dout_low("fill");
        n = 0;
        while (tx_busy && n < 5 * 10 * BIT) begin
            @(negedge sclk);
            n++;
        end
        check("fill_no_gap_clocks", n, 4 * 10 * BIT);
        wait_idle("fill", 2000);

        // Overrun: five frames without draining
        loop     = 1'b0;
        drain_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            b = 8'(8'h10 + i);
            expect_rx(b);
            drive_frame(b, 1'b1);
        end
        repeat (50) @(negedge sclk);
        check("ovr_flag_set", int'(rx_overrun), int'(ovr_exp));
        check("ovr_rx_valid", int'(rx_valid), 1);
        err_clr = 1'b1;
        @(negedge sclk);
        err_clr = 1'b0;
        ovr_exp = 1'b0;
        check("ovr_flag_clr", int'(rx_overrun), int'(ovr_exp));
        drain_en = 1'b1;
        wait_idle("ovr", 200);

        // Stop bit low: framing error, nothing pushed
        drive_frame(8'h7E, 1'b0);
        fe_exp = 1'b1;
        repeat (50) @(negedge sclk);
        check("fe_flag_set", int'(rx_frame_err), int'(fe_exp));
        check("fe_no_push", int'(rx_valid), 0);
        check("fe_no_overrun", int'(rx_overrun), 0);
        err_clr = 1'b1;
        @(negedge sclk);
        err_clr = 1'b0;
        fe_exp  = 1'b0;
        check("fe_flag_clr", int'(rx_frame_err), int'(fe_exp));

        // 4-tick low glitch is rejected
        bench_din = 1'b0;
        repeat (4 * 27) @(negedge sclk);
        bench_din = 1'b1;
        repeat (2 * BIT) @(negedge sclk);
        check("glitch_no_valid", int'(rx_valid), 0);
        check("glitch_no_fe", int'(rx_frame_err), 0);
        check("glitch_no_ovr", int'(rx_overrun), 0);

        // Random loopback bytes with random spacing
        loop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(0, 600)) @(negedge sclk);
            n = 0;
            while (tx_full && n < 20000) begin
                @(negedge sclk);
                n++;
            end
            b = 8'($urandom_range(0, 255));
            tx_exp.push_back(b);
            expect_rx(b);
            push_tx(b);
        end
        wait_idle("rand", 20000);

        check("end_tx_queue_empty", tx_exp.size(), 0);
        check("end_rx_queue_empty", rx_exp.size(), 0);
        check("end_overrun", int'(rx_overrun), int'(ovr_exp));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
